// File: rtl/cpu_mem_loader.sv
// Streams a memory image into the cpu's external dmem/imem ports, then releases the cpu.
// Dmem is written first (port _2), then imem (port 1); cpu_enable rises after a settle gap.
module cpu_mem_loader #(
   parameter int unsigned IMEM_SIZE     = 512,
   parameter int unsigned DMEM_SIZE     = 1024,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [9:0]  imem_words,
   input  logic [10:0] dmem_words,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic        halt,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   output logic [63:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [63:0] wdata_ext_2,
   output logic        cpu_enable,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_D = 3'd1;
   localparam logic [2:0] ST_LOAD_I = 3'd2;
   localparam logic [2:0] ST_SETTLE = 3'd3;
   localparam logic [2:0] ST_RUN    = 3'd4;

   localparam logic [10:0] IMEM_MAX    = 11'(IMEM_SIZE);
   localparam logic [11:0] DMEM_MAX    = 12'(DMEM_SIZE);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES);

   logic [2:0]  state_q, state_d;
   logic [10:0] dcnt_q, dcnt_d;
   logic [9:0]  icnt_q, icnt_d;
   logic [10:0] idx_q, idx_d;
   logic [15:0] idle_q, idle_d;
   logic        wen_q, wen_d;
   logic [63:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wen2_q, wen2_d;
   logic [63:0] waddr2_q, waddr2_d;
   logic [63:0] wdata2_q, wdata2_d;
   logic        cpu_en_q, cpu_en_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        beat;

   assign in_ready = ((state_q == ST_LOAD_D) && (idx_q < dcnt_q)) ||
                     ((state_q == ST_LOAD_I) && (idx_q < {1'b0, icnt_q}));
   assign beat     = in_valid & in_ready;

   always_comb begin
      state_d  = state_q;
      dcnt_d   = dcnt_q;
      icnt_d   = icnt_q;
      idx_d    = idx_q;
      cpu_en_d = cpu_en_q;
      error_d  = error_q;
      done_d   = 1'b0;
      wen_d    = 1'b0;
      waddr_d  = '0;
      wdata_d  = '0;
      wen2_d   = 1'b0;
      waddr2_d = '0;
      wdata2_d = '0;
      // idle_q counts cycles since the most recent write strobe, saturating
      idle_d   = (idle_q >= SETTLE_LAST) ? idle_q : idle_q + 16'd1;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (({1'b0, imem_words} > IMEM_MAX) || ({1'b0, dmem_words} > DMEM_MAX)) begin
                  error_d = 1'b1;
               end else begin
                  dcnt_d  = dmem_words;
                  icnt_d  = imem_words;
                  idx_d   = '0;
                  idle_d  = '0;
                  error_d = 1'b0;
                  state_d = ST_LOAD_D;
               end
            end
         end
         ST_LOAD_D: begin
            if (dcnt_q == 11'd0) begin
               idx_d   = '0;
               state_d = ST_LOAD_I;
            end else if (beat) begin
               wen2_d   = 1'b1;
               waddr2_d = {50'd0, idx_q, 3'd0};
               wdata2_d = in_data;
               if (idx_q + 11'd1 == dcnt_q) begin
                  idx_d   = '0;
                  state_d = ST_LOAD_I;
               end else begin
                  idx_d = idx_q + 11'd1;
               end
            end
         end
         ST_LOAD_I: begin
            if (icnt_q == 10'd0) begin
               state_d = ST_SETTLE;
            end else if (beat) begin
               wen_d   = 1'b1;
               waddr_d = {51'd0, idx_q, 2'd0};
               wdata_d = in_data[31:0];
               if (idx_q + 11'd1 == {1'b0, icnt_q}) begin
                  idx_d   = '0;
                  state_d = ST_SETTLE;
               end else begin
                  idx_d = idx_q + 11'd1;
               end
            end
         end
         ST_SETTLE: begin
            if (idle_q >= SETTLE_LAST) begin
               cpu_en_d = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (halt) begin
               cpu_en_d = 1'b0;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (wen_d || wen2_d) begin
         idle_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         dcnt_q   <= '0;
         icnt_q   <= '0;
         idx_q    <= '0;
         idle_q   <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wen2_q   <= 1'b0;
         waddr2_q <= '0;
         wdata2_q <= '0;
         cpu_en_q <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         dcnt_q   <= dcnt_d;
         icnt_q   <= icnt_d;
         idx_q    <= idx_d;
         idle_q   <= idle_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         wen2_q   <= wen2_d;
         waddr2_q <= waddr2_d;
         wdata2_q <= wdata2_d;
         cpu_en_q <= cpu_en_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign addr_ext    = waddr_q;
   assign wen_ext     = wen_q;
   assign ren_ext     = 1'b0;
   assign wdata_ext   = wdata_q;
   assign addr_ext_2  = waddr2_q;
   assign wen_ext_2   = wen2_q;
   assign ren_ext_2   = 1'b0;
   assign wdata_ext_2 = wdata2_q;
   assign cpu_enable  = cpu_en_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign error       = error_q;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Bench for cpu_mem_loader: table of load scenarios plus hand-written corner sequences;
// every accepted beat pushes its expected write onto a scoreboard popped by a strobe monitor.
module tb_cpu_mem_loader;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  imem_words;
   logic [10:0] dmem_words;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        halt;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic        cpu_enable;
   logic        busy;
   logic        done;
   logic        error;

   cpu_mem_loader #(
      .IMEM_SIZE(512),
      .DMEM_SIZE(1024),
      .SETTLE_CYCLES(S)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .imem_words(imem_words), .dmem_words(dmem_words),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .halt(halt),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2), .cpu_enable(cpu_enable), .busy(busy), .done(done),
      .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int nd;
      int ni;
      bit err;
   } vec_t;

   typedef struct {
      bit          is_d;
      logic [63:0] addr;
      logic [63:0] data;
   } wr_t;

   wr_t  sb[$];
   vec_t vecs[8];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_wr_cyc = 0;
   int   n_writes = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Strobe monitor: pops the scoreboard on every write strobe, otherwise expects zeroed buses.
   always @(negedge clk) begin
      wr_t e;
      check("ren_zero", {62'd0, ren_ext, ren_ext_2}, 64'd0);
      if (wen_ext && wen_ext_2) begin
         check("dual_strobe", 64'd1, 64'd0);
      end else if (wen_ext || wen_ext_2) begin
         last_wr_cyc = cyc;
         n_writes++;
         if (sb.size() == 0) begin
            check("unexpected_strobe", {63'd0, wen_ext_2}, 64'hdead);
         end else begin
            e = sb.pop_front();
            check("wr_port", {63'd0, wen_ext_2}, {63'd0, e.is_d});
            check("wr_addr", e.is_d ? addr_ext_2 : addr_ext, e.addr);
            check("wr_data", e.is_d ? wdata_ext_2 : {32'd0, wdata_ext}, e.data);
         end
      end else begin
         check("idle_bus", addr_ext | addr_ext_2 | wdata_ext_2 | {32'd0, wdata_ext}, 64'd0);
      end
   end

   // Entered and left just after a rising edge.
   task automatic send_beat(input bit is_d, input int k);
      logic [63:0] d;
      wr_t e;
      bit ok;
      d = {$urandom, $urandom};
      in_valid = 1'b1;
      in_data  = d;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.is_d = is_d;
            e.addr = is_d ? 64'(k) << 3 : 64'(k) << 2;
            e.data = is_d ? d : {32'd0, d[31:0]};
            sb.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) check("beat_timeout", 64'd0, 64'd1);
   endtask

   task automatic pulse_start(input int nd, input int ni);
      start      = 1'b1;
      dmem_words = 11'(nd);
      imem_words = 10'(ni);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic finish_run(input bit had_writes);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk);
         if (cpu_enable) seen = 1'b1;
      end
      check("cpu_enable_rise", {63'd0, seen}, 64'd1);
      if (had_writes) check("settle_gap", 64'(cyc - last_wr_cyc), 64'(S + 1));
      check("run_busy", {63'd0, busy}, 64'd1);
      repeat (3) @(negedge clk);
      check("run_hold", {62'd0, cpu_enable, done}, 64'h2);
      @(posedge clk);
      #1;
      halt = 1'b1;
      @(posedge clk);
      #1;
      halt = 1'b0;
      @(negedge clk);
      check("halt_state", {61'd0, cpu_enable, done, busy}, 64'h2);
      @(negedge clk);
      check("done_pulse", {63'd0, done}, 64'd0);
      check("sb_empty", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_load(input int nd, input int ni, input bit exp_err);
      int w0;
      w0 = n_writes;
      pulse_start(nd, ni);
      @(negedge clk);
      check("start_error", {63'd0, error}, {63'd0, exp_err});
      check("start_busy", {63'd0, busy}, {63'd0, !exp_err});
      @(posedge clk);
      #1;
      if (exp_err) begin
         repeat (3) @(negedge clk);
         check("err_sticky", {62'd0, error, busy}, 64'h2);
         check("err_no_write", 64'(n_writes - w0), 64'd0);
         @(posedge clk);
         #1;
      end else begin
         for (int k = 0; k < nd; k++) send_beat(1'b1, k);
         for (int k = 0; k < ni; k++) send_beat(1'b0, k);
         finish_run((nd + ni) > 0);
         check("write_count", 64'(n_writes - w0), 64'(nd + ni));
      end
      $display("load dmem=%0d imem=%0d exp_err=%0b error=%0b writes=%0d", nd, ni, exp_err,
               error, n_writes - w0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{nd: 2,    ni: 3,   err: 1'b0};
      vecs[1] = '{nd: 0,    ni: 1,   err: 1'b0};
      vecs[2] = '{nd: 0,    ni: 513, err: 1'b1};
      vecs[3] = '{nd: 1,    ni: 0,   err: 1'b0};
      vecs[4] = '{nd: 0,    ni: 0,   err: 1'b0};
      vecs[5] = '{nd: 1025, ni: 0,   err: 1'b1};
      vecs[6] = '{nd: 3,    ni: 512, err: 1'b0};
      vecs[7] = '{nd: 1024, ni: 1,   err: 1'b0};

      rst = 1'b1; start = 1'b0; halt = 1'b0; in_valid = 1'b0; in_data = '0;
      imem_words = '0; dmem_words = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", {58'd0, in_ready, wen_ext, wen_ext_2, cpu_enable, busy, done}, 64'd0);
      check("reset_error", {63'd0, error}, 64'd0);

      // Words offered while idle must not be consumed; halt while idle does nothing.
      in_valid = 1'b1; in_data = 64'h1234; halt = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_in_ready", {61'd0, in_ready, busy, done}, 64'd0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; halt = 1'b0;

      foreach (vecs[i]) run_load(vecs[i].nd, vecs[i].ni, vecs[i].err);

      // Gapped stream in LOAD_D, with ignored start/halt during the gap.
      pulse_start(3, 1);
      send_beat(1'b1, 0);
      halt = 1'b1; start = 1'b1; imem_words = 10'd600; dmem_words = 11'd0;
      @(negedge clk);
      check("gap_ready", {62'd0, in_ready, busy}, 64'h3);
      check("gap_strobe", {63'd0, wen_ext_2}, 64'd1);
      @(posedge clk);
      #1;
      halt = 1'b0; start = 1'b0;
      @(negedge clk);
      check("gap_ignored", {61'd0, error, done, busy}, 64'd1);
      @(posedge clk);
      #1;
      send_beat(1'b1, 1);
      send_beat(1'b1, 2);
      send_beat(1'b0, 0);
      finish_run(1'b1);
      $display("load gapped dmem=3 imem=1 error=%0b", error);

      // Reset in the middle of a dmem section.
      pulse_start(4, 1);
      send_beat(1'b1, 0);
      send_beat(1'b1, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_outputs", {58'd0, in_ready, wen_ext, wen_ext_2, cpu_enable, busy, done}, 64'd0);
      check("midrst_bus", addr_ext | addr_ext_2 | wdata_ext_2 | {32'd0, wdata_ext}, 64'd0);
      check("midrst_sb", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
      $display("reset mid-load after 2 of 4 dmem beats");
      run_load(2, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
